// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port, decode handshake and branch redirect.
// master = fetch unit, slave = memory/decode/branch environment.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic [31:0] ext_imm;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, instr_ready, branch_taken, branch_pc, ext_imm
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, instr_ready, branch_taken, branch_pc, ext_imm
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// ARMv4 fetch stage: owns the PC, keeps one word read outstanding at most, queues returned
// instructions in order for decode and redirects on taken branches (target = branch_pc + 8 + ext_imm).
//
// state | meaning
// IDLE  | no read outstanding
// WAIT  | read outstanding, returned data is kept
// DRAIN | read outstanding, returned data is discarded (redirect happened)
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input logic          clk,
  input logic          reset,
  instr_fetch_unit_if.master bus
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DRAIN = 2'd2} state_t;

  state_t        state_q, state_d;
  logic          imem_req_q, imem_req_d;
  logic [31:0]   imem_addr_q, imem_addr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   q_instr_q [QDEPTH];
  logic [31:0]   q_instr_d [QDEPTH];
  logic [31:0]   q_pc_q    [QDEPTH];
  logic [31:0]   q_pc_d    [QDEPTH];

  logic        redirect;
  logic        ack;
  logic        has_space;
  logic        issue;
  logic        push;
  logic        pop;
  logic [31:0] target;

  assign redirect  = bus.branch_taken;
  // an ack only counts while a read is actually outstanding
  assign ack       = bus.imem_ack & imem_req_q;
  assign has_space = (count_q < CW'(QDEPTH));
  assign issue     = (state_q == IDLE) & ~redirect & has_space;
  assign push      = (state_q == WAIT) & ack & ~redirect;
  assign pop       = (count_q != '0) & bus.instr_ready & ~redirect;
  assign target    = (bus.branch_pc + 32'd8 + bus.ext_imm) & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = WAIT;
      WAIT: begin
        if (ack)           state_d = IDLE;
        else if (redirect) state_d = DRAIN;
      end
      DRAIN:   if (ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    fetch_pc_d  = fetch_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    q_instr_d   = q_instr_q;
    q_pc_d      = q_pc_q;

    if (issue) begin
      imem_req_d  = 1'b1;
      imem_addr_d = fetch_pc_q;
    end
    if (ack) imem_req_d = 1'b0;

    if (redirect) begin
      fetch_pc_d = target;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        q_instr_d[wr_ptr_q] = bus.imem_rdata;
        q_pc_d[wr_ptr_q]    = imem_addr_q;
        wr_ptr_d            = wr_ptr_q + PW'(1);
        fetch_pc_d          = imem_addr_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
      fetch_pc_q  <= RESET_PC;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        q_instr_q[i] <= '0;
        q_pc_q[i]    <= '0;
      end
    end else begin
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      fetch_pc_q  <= fetch_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      q_instr_q   <= q_instr_d;
      q_pc_q      <= q_pc_d;
    end
  end

  assign bus.imem_req    = imem_req_q;
  assign bus.imem_addr   = imem_addr_q;
  assign bus.instr_valid = (count_q != '0);
  // head reads as zero when empty so a flushed queue shows no stale word
  assign bus.instr       = (count_q != '0) ? q_instr_q[rd_ptr_q] : 32'd0;
  assign bus.instr_pc    = (count_q != '0) ? q_pc_q[rd_ptr_q]    : 32'd0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed table-driven bench for instr_fetch_unit: one table row per clock edge,
// plus a hand-written reset-during-read sequence.
module tb_instr_fetch_unit;

  localparam logic [31:0] W0 = 32'hE3A01005;
  localparam logic [31:0] W1 = 32'hE2811001;
  localparam logic [31:0] W2 = 32'hEAFFFFFE;
  localparam logic [31:0] W3 = 32'hE1A00000;
  localparam int NV = 25;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        br;
    logic [31:0] bpc;
    logic [31:0] imm;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] ins;
    logic [31:0] ipc;
  } vec_t;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  vec_t tbl [NV];

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t v(input logic ack, input logic [31:0] rdata, input logic rdy,
                             input logic br, input logic [31:0] bpc, input logic [31:0] imm,
                             input logic req, input logic [31:0] addr, input logic vld,
                             input logic [31:0] ins, input logic [31:0] ipc);
    vec_t r;
    r.ack = ack; r.rdata = rdata; r.rdy = rdy; r.br = br; r.bpc = bpc; r.imm = imm;
    r.req = req; r.addr = addr; r.vld = vld; r.ins = ins; r.ipc = ipc;
    return r;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %h, want %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_outs(input int idx, input logic req, input logic [31:0] addr,
                          input logic vld, input logic [31:0] ins, input logic [31:0] ipc);
    n_vec++;
    chk("imem_req",    idx, {31'd0, bus.imem_req},    {31'd0, req});
    chk("imem_addr",   idx, bus.imem_addr,            addr);
    chk("instr_valid", idx, {31'd0, bus.instr_valid}, {31'd0, vld});
    chk("instr",       idx, bus.instr,                ins);
    chk("instr_pc",    idx, bus.instr_pc,             ipc);
  endtask

  task automatic drive(input logic ack, input logic [31:0] rdata, input logic rdy,
                       input logic br, input logic [31:0] bpc, input logic [31:0] imm);
    bus.imem_ack     = ack;
    bus.imem_rdata   = rdata;
    bus.instr_ready  = rdy;
    bus.branch_taken = br;
    bus.branch_pc    = bpc;
    bus.ext_imm      = imm;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    //        ack rdata         rdy br bpc           imm           req addr          vld ins ipc
    tbl[0]  = v(0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h0,        0, 32'h0, 32'h0);
    tbl[1]  = v(1, W0,           0, 0, 32'h0,        32'h0,        0, 32'h0,        1, W0,    32'h0);
    tbl[2]  = v(0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h4,        1, W0,    32'h0);
    tbl[3]  = v(1, W1,           0, 0, 32'h0,        32'h0,        0, 32'h4,        1, W0,    32'h0);
    tbl[4]  = v(0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 32'h4,        1, W0,    32'h0);
    tbl[5]  = v(0, 32'h0,        0, 0, 32'h0,        32'h0,        0, 32'h4,        1, W0,    32'h0);
    tbl[6]  = v(0, 32'h0,        1, 0, 32'h0,        32'h0,        0, 32'h4,        1, W1,    32'h4);
    tbl[7]  = v(0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h8,        1, W1,    32'h4);
    tbl[8]  = v(1, W2,           1, 0, 32'h0,        32'h0,        0, 32'h8,        1, W2,    32'h8);
    tbl[9]  = v(0, 32'h0,        1, 0, 32'h0,        32'h0,        1, 32'hC,        0, 32'h0, 32'h0);
    tbl[10] = v(1, W3,           0, 0, 32'h0,        32'h0,        0, 32'hC,        1, W3,    32'hC);
    tbl[11] = v(0, 32'h0,        1, 1, 32'h10,       32'hFFFFFFF8, 0, 32'hC,        0, 32'h0, 32'h0);
    tbl[12] = v(0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h10,       0, 32'h0, 32'h0);
    tbl[13] = v(0, 32'h0,        1, 1, 32'h0,        32'h100,      1, 32'h10,       0, 32'h0, 32'h0);
    tbl[14] = v(0, 32'h0,        1, 0, 32'h0,        32'h0,        1, 32'h10,       0, 32'h0, 32'h0);
    tbl[15] = v(1, 32'hDEADBEEF, 1, 0, 32'h0,        32'h0,        0, 32'h10,       0, 32'h0, 32'h0);
    tbl[16] = v(0, 32'h0,        1, 0, 32'h0,        32'h0,        1, 32'h108,      0, 32'h0, 32'h0);
    tbl[17] = v(1, 32'h12345678, 1, 1, 32'hFFFFFFF8, 32'h0,        0, 32'h108,      0, 32'h0, 32'h0);
    tbl[18] = v(0, 32'h0,        1, 0, 32'h0,        32'h0,        1, 32'h0,        0, 32'h0, 32'h0);
    tbl[19] = v(0, 32'h0,        1, 1, 32'h20,       32'h4,        1, 32'h0,        0, 32'h0, 32'h0);
    tbl[20] = v(0, 32'h0,        1, 1, 32'h40,       32'h1,        1, 32'h0,        0, 32'h0, 32'h0);
    tbl[21] = v(1, 32'hCAFEF00D, 1, 0, 32'h0,        32'h0,        0, 32'h0,        0, 32'h0, 32'h0);
    tbl[22] = v(0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h48,       0, 32'h0, 32'h0);
    tbl[23] = v(1, W0,           0, 0, 32'h0,        32'h0,        0, 32'h48,       1, W0,    32'h48);
    tbl[24] = v(0, 32'h0,        0, 0, 32'h0,        32'h0,        1, 32'h4C,       1, W0,    32'h48);

    drive(0, 32'h0, 0, 0, 32'h0, 32'h0);
    reset = 1'b0;
    #2;
    chk_outs(-1, 0, 32'h0, 0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].ack, tbl[i].rdata, tbl[i].rdy, tbl[i].br, tbl[i].bpc, tbl[i].imm);
      @(posedge clk);
      #1;
      chk_outs(i, tbl[i].req, tbl[i].addr, tbl[i].vld, tbl[i].ins, tbl[i].ipc);
    end

    // reset asserted mid-WAIT (read to 0x4C outstanding): outputs drop with no clock edge
    #2;
    reset = 1'b0;
    #1;
    chk_outs(100, 0, 32'h0, 0, 32'h0, 32'h0);

    @(negedge clk);
    drive(1, W2, 1, 0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    chk_outs(101, 0, 32'h0, 0, 32'h0, 32'h0);

    // late ack still high on the first edge after release must not be taken as data
    @(negedge clk);
    reset = 1'b1;
    drive(1, W2, 0, 0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    chk_outs(102, 1, 32'h0, 0, 32'h0, 32'h0);

    @(negedge clk);
    drive(1, W1, 0, 0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    chk_outs(103, 0, 32'h0, 1, W1, 32'h0);

    @(negedge clk);
    drive(0, 32'h0, 0, 0, 32'h0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
